// File: rtl/coeff_interp_pkg.sv
// HEVC interpolation coefficient tables (luma 8-tap quarter-pel, chroma 4-tap eighth-pel)
// and the lookup helper shared by the coefficient source actor.
package coeff_interp_pkg;

  typedef logic signed [8:0] coeff_t;

  // Luma rows are indexed by alpha/2: only even eighth-pel positions exist.
  localparam coeff_t LUMA_COEFF [4][8] = '{
    '{ 9'sd0,  9'sd0,  9'sd0,   9'sd64,  9'sd0,   9'sd0,   9'sd0,  9'sd0},
    '{-9'sd1,  9'sd4, -9'sd10,  9'sd58,  9'sd17, -9'sd5,   9'sd1,  9'sd0},
    '{-9'sd1,  9'sd4, -9'sd11,  9'sd40,  9'sd40, -9'sd11,  9'sd4, -9'sd1},
    '{ 9'sd0,  9'sd1, -9'sd5,   9'sd17,  9'sd58, -9'sd10,  9'sd4, -9'sd1}
  };

  localparam coeff_t CHROMA_COEFF [8][4] = '{
    '{ 9'sd0,  9'sd64,  9'sd0,   9'sd0},
    '{-9'sd2,  9'sd58,  9'sd10, -9'sd2},
    '{-9'sd4,  9'sd54,  9'sd16, -9'sd2},
    '{-9'sd6,  9'sd46,  9'sd28, -9'sd4},
    '{-9'sd4,  9'sd36,  9'sd36, -9'sd4},
    '{-9'sd4,  9'sd28,  9'sd46, -9'sd6},
    '{-9'sd2,  9'sd16,  9'sd54, -9'sd4},
    '{-9'sd2,  9'sd10,  9'sd58, -9'sd2}
  };

  // Odd luma alpha folds onto the even row below it (alpha & ~1).
  function automatic coeff_t get_coeff(input int ntap, input logic [2:0] alpha,
                                       input logic [2:0] k);
    if (ntap == 8) return LUMA_COEFF[alpha[2:1]][k];
    return CHROMA_COEFF[alpha][k[1:0]];
  endfunction

endpackage

// File: rtl/coeff_interp_ntap_rr_arbiter_flux.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter_flux #(
  parameter int FLUX      = 2,
  parameter int TAG_WIDTH = 1
) (
  input  logic [FLUX-1:0]      req_i,
  input  logic [TAG_WIDTH-1:0] ptr_i,
  output logic [FLUX-1:0]      gnt_o,
  output logic [TAG_WIDTH-1:0] gnt_idx_o,
  output logic                 gnt_v_o
);

  always_comb begin
    logic [TAG_WIDTH-1:0] idx;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_v_o   = 1'b0;
    idx       = '0;
    for (int i = 0; i < FLUX; i++) begin
      idx = TAG_WIDTH'((int'(ptr_i) + i) % FLUX);
      if (!gnt_v_o && req_i[idx]) begin
        gnt_v_o    = 1'b1;
        gnt_idx_o  = idx;
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coeff_interp_ntap.sv
// Multi-flux HEVC coefficient source: pops tagged alpha tokens, pushes NTAP tagged coefficients.
// Optional sticky odd-luma-alpha flags when COEFF_ALPHA_ERR_EN is defined; each flux's head is on its own dout lane.
module coeff_interp_ntap
  import coeff_interp_pkg::*;
#(
  parameter  int FLUX        = 2,
  parameter  int NTAP        = 8,
  parameter  int COEFF_WIDTH = 9,
  parameter  int FRAC_WIDTH  = 3,
  localparam int TAG_WIDTH   = (FLUX > 1) ? $clog2(FLUX) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
`ifdef COEFF_ALPHA_ERR_EN
  output logic [FLUX-1:0]                  err_alpha_o,
`endif
  input  logic [TAG_WIDTH+FRAC_WIDTH-1:0]  read_port_alpha_dout_i [FLUX],
  input  logic [FLUX-1:0]                  read_port_alpha_empty_i,
  output logic [FLUX-1:0]                  read_port_alpha_read_o,
  output logic [TAG_WIDTH+COEFF_WIDTH-1:0] write_port_c_din_o [NTAP],
  input  logic [FLUX-1:0]                  write_port_c_full_i [NTAP],
  output logic [NTAP-1:0]                  write_port_c_write_o
);

  if (NTAP != 8 && NTAP != 4) begin : g_bad_ntap
    $error("coeff_interp_ntap: NTAP must be 4 (chroma) or 8 (luma)");
  end

  logic [FLUX-1:0]       hold_v_q, hold_v_d;
  logic [FRAC_WIDTH-1:0] hold_a_q [FLUX];
  logic [TAG_WIDTH-1:0]  rr_acc_q, rr_acc_d, rr_drn_q, rr_drn_d;

  logic [FLUX-1:0]       blocked, drn_req, acc_req, drn_gnt, acc_gnt;
  logic [TAG_WIDTH-1:0]  drn_idx, acc_idx;
  logic                  drn_v, acc_v;
  logic                  unused_tags;

  function automatic logic [TAG_WIDTH-1:0] next_ptr(input logic [TAG_WIDTH-1:0] p);
    return (int'(p) == FLUX - 1) ? '0 : p + 1'b1;
  endfunction

  // A flux stalls if any of its coefficient FIFOs is full; rst forces all requests off.
  always_comb begin
    blocked     = '0;
    unused_tags = 1'b0;
    for (int k = 0; k < NTAP; k++) blocked |= write_port_c_full_i[k];
    for (int f = 0; f < FLUX; f++)
      unused_tags ^= ^read_port_alpha_dout_i[f][TAG_WIDTH+FRAC_WIDTH-1:FRAC_WIDTH];
    drn_req = hold_v_q & ~blocked & {FLUX{~rst}};
  end

  rr_arbiter_flux #(.FLUX(FLUX), .TAG_WIDTH(TAG_WIDTH)) u_drn_arb (
    .req_i     (drn_req),
    .ptr_i     (rr_drn_q),
    .gnt_o     (drn_gnt),
    .gnt_idx_o (drn_idx),
    .gnt_v_o   (drn_v)
  );

  // An occupied slot can take a new token in the same cycle it drains.
  assign acc_req = ~read_port_alpha_empty_i & (~hold_v_q | drn_gnt) & {FLUX{~rst}};

  rr_arbiter_flux #(.FLUX(FLUX), .TAG_WIDTH(TAG_WIDTH)) u_acc_arb (
    .req_i     (acc_req),
    .ptr_i     (rr_acc_q),
    .gnt_o     (acc_gnt),
    .gnt_idx_o (acc_idx),
    .gnt_v_o   (acc_v)
  );

  assign read_port_alpha_read_o = acc_gnt;
  assign write_port_c_write_o   = {NTAP{drn_v}};

  always_comb begin
    for (int k = 0; k < NTAP; k++) begin
      write_port_c_din_o[k] = '0;
      if (drn_v)
        write_port_c_din_o[k] = {drn_idx,
          COEFF_WIDTH'(get_coeff(NTAP, 3'(hold_a_q[drn_idx]), 3'(k)))};
    end
  end

  always_comb begin
    hold_v_d = (hold_v_q & ~drn_gnt) | acc_gnt;
    rr_drn_d = drn_v ? next_ptr(drn_idx) : rr_drn_q;
    rr_acc_d = acc_v ? next_ptr(acc_idx) : rr_acc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v_q <= '0;
      rr_acc_q <= '0;
      rr_drn_q <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      rr_acc_q <= rr_acc_d;
      rr_drn_q <= rr_drn_d;
    end
  end

  // Alpha payload needs no reset: it is only observed while hold_v_q is set.
  always_ff @(posedge clk) begin
    for (int f = 0; f < FLUX; f++)
      if (acc_gnt[f]) hold_a_q[f] <= read_port_alpha_dout_i[f][FRAC_WIDTH-1:0];
  end

`ifdef COEFF_ALPHA_ERR_EN
  logic [FLUX-1:0] err_q, err_d, odd_alpha;

  always_comb begin
    for (int f = 0; f < FLUX; f++)
      odd_alpha[f] = (NTAP == 8) && read_port_alpha_dout_i[f][0];
    err_d = err_q | (acc_gnt & odd_alpha);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_alpha_o = err_q;
`endif

  a_read_nonempty: assert property (@(posedge clk) disable iff (rst)
    (read_port_alpha_read_o & read_port_alpha_empty_i) == '0);

  for (genvar k = 0; k < NTAP; k++) begin : g_wr_chk
    a_write_notfull: assert property (@(posedge clk) disable iff (rst)
      !(write_port_c_write_o[k] && write_port_c_full_i[k][drn_idx]));
  end

endmodule

// File: tb/tb_coeff_interp_ntap.sv
// Directed bench for coeff_interp_ntap: one luma (NTAP=8) and one chroma (NTAP=4) instance, FLUX=2.
module tb_coeff_interp_ntap;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] l_dout [2];
  logic [1:0] l_empty, l_read;
  logic [9:0] l_din [8];
  logic [1:0] l_full [8];
  logic [7:0] l_write;

  logic [3:0] c_dout [2];
  logic [1:0] c_empty, c_read;
  logic [9:0] c_din [4];
  logic [1:0] c_full [4];
  logic [3:0] c_write;

`ifdef COEFF_ALPHA_ERR_EN
  logic [1:0] l_err, c_err;
`endif

  coeff_interp_ntap #(.FLUX(2), .NTAP(8), .COEFF_WIDTH(9), .FRAC_WIDTH(3)) u_luma (
    .clk                     (clk),
    .rst                     (rst),
`ifdef COEFF_ALPHA_ERR_EN
    .err_alpha_o             (l_err),
`endif
    .read_port_alpha_dout_i  (l_dout),
    .read_port_alpha_empty_i (l_empty),
    .read_port_alpha_read_o  (l_read),
    .write_port_c_din_o      (l_din),
    .write_port_c_full_i     (l_full),
    .write_port_c_write_o    (l_write)
  );

  coeff_interp_ntap #(.FLUX(2), .NTAP(4), .COEFF_WIDTH(9), .FRAC_WIDTH(3)) u_chroma (
    .clk                     (clk),
    .rst                     (rst),
`ifdef COEFF_ALPHA_ERR_EN
    .err_alpha_o             (c_err),
`endif
    .read_port_alpha_dout_i  (c_dout),
    .read_port_alpha_empty_i (c_empty),
    .read_port_alpha_read_o  (c_read),
    .write_port_c_din_o      (c_din),
    .write_port_c_full_i     (c_full),
    .write_port_c_write_o    (c_write)
  );

  typedef struct packed {
    logic            chroma;
    logic            flux;
    logic [2:0]      alpha;
    logic [7:0][8:0] c;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs [14];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input bit ch, input bit f, input int a,
                              input int c0, input int c1, input int c2, input int c3,
                              input int c4, input int c5, input int c6, input int c7);
    vec_t v;
    v.chroma = ch; v.flux = f; v.alpha = 3'(a); v.c = '0;
    v.c[0] = 9'(c0); v.c[1] = 9'(c1); v.c[2] = 9'(c2); v.c[3] = 9'(c3);
    v.c[4] = 9'(c4); v.c[5] = 9'(c5); v.c[6] = 9'(c6); v.c[7] = 9'(c7);
    return v;
  endfunction

  function automatic int coef(input logic [9:0] d);
    return int'($signed(d[8:0]));
  endfunction

  task automatic do_reset();
    l_empty = 2'b11; c_empty = 2'b11;
    for (int k = 0; k < 8; k++) l_full[k] = 2'b00;
    for (int k = 0; k < 4; k++) c_full[k] = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int nt;
    logic [9:0] d;
    nt = v.chroma ? 4 : 8;
    tick();
    if (v.chroma) begin c_dout[v.flux] = {v.flux, v.alpha}; c_empty[v.flux] = 1'b0; end
    else          begin l_dout[v.flux] = {v.flux, v.alpha}; l_empty[v.flux] = 1'b0; end
    #1;
    chk($sformatf("v%0d read", idx), v.chroma ? int'(c_read) : int'(l_read), 1 << v.flux);
    chk($sformatf("v%0d write_pre", idx), v.chroma ? int'(c_write) : int'(l_write), 0);
    tick();
    l_empty = 2'b11; c_empty = 2'b11;
    #1;
    chk($sformatf("v%0d write", idx), v.chroma ? int'(c_write) : int'(l_write), v.chroma ? 'hF : 'hFF);
    chk($sformatf("v%0d read_post", idx), v.chroma ? int'(c_read) : int'(l_read), 0);
    for (int k = 0; k < nt; k++) begin
      d = v.chroma ? c_din[k & 3] : l_din[k];
      chk($sformatf("v%0d tag%0d", idx, k), int'(d[9]), int'(v.flux));
      chk($sformatf("v%0d coef%0d", idx, k), coef(d), int'($signed(v.c[k])));
    end
    tick();
    #1;
    chk($sformatf("v%0d write_done", idx), v.chroma ? int'(c_write) : int'(l_write), 0);
  endtask

  initial begin
    int exp4 [8];
    exp4 = '{-1, 4, -11, 40, 40, -11, 4, -1};

    vecs[0]  = mk(0, 0, 2, -1, 4, -10, 58, 17, -5, 1, 0);
    vecs[1]  = mk(0, 1, 0,  0, 0,   0, 64,  0,  0, 0, 0);
    vecs[2]  = mk(0, 0, 4, -1, 4, -11, 40, 40, -11, 4, -1);
    vecs[3]  = mk(0, 1, 6,  0, 1,  -5, 17, 58, -10, 4, -1);
    vecs[4]  = mk(0, 0, 5, -1, 4, -11, 40, 40, -11, 4, -1);
    vecs[5]  = mk(0, 1, 1,  0, 0,   0, 64,  0,  0, 0, 0);
    vecs[6]  = mk(1, 1, 3, -6, 46, 28, -4, 0, 0, 0, 0);
    vecs[7]  = mk(1, 1, 0,  0, 64,  0,  0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 1, -2, 58, 10, -2, 0, 0, 0, 0);
    vecs[9]  = mk(1, 0, 5, -4, 28, 46, -6, 0, 0, 0, 0);
    vecs[10] = mk(1, 1, 7, -2, 10, 58, -2, 0, 0, 0, 0);
    vecs[11] = mk(1, 0, 4, -4, 36, 36, -4, 0, 0, 0, 0);
    vecs[12] = mk(1, 1, 2, -4, 54, 16, -2, 0, 0, 0, 0);
    vecs[13] = mk(1, 0, 6, -2, 16, 54, -4, 0, 0, 0, 0);

    // Reset state with non-empty inputs: outputs must stay quiet.
    l_dout[0] = 4'b0_010; l_dout[1] = 4'b1_100;
    c_dout[0] = 4'b0_000; c_dout[1] = 4'b1_000;
    for (int k = 0; k < 8; k++) l_full[k] = 2'b00;
    for (int k = 0; k < 4; k++) c_full[k] = 2'b00;
    l_empty = 2'b00; c_empty = 2'b00;
    #2;
    chk("rst l_read", int'(l_read), 0);
    chk("rst l_write", int'(l_write), 0);
    chk("rst l_din0", int'(l_din[0]), 0);
    chk("rst c_read", int'(c_read), 0);
    chk("rst c_write", int'(c_write), 0);
    do_reset();

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Both fluxes always available: strict alternation, one write per cycle.
    do_reset();
    l_dout[0] = 4'b0_010; l_dout[1] = 4'b1_100;
    tick();
    l_empty = 2'b00;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("stream read c%0d", i), int'(l_read), (i % 2 == 0) ? 1 : 2);
      if (i == 0) chk("stream write c0", int'(l_write), 0);
      else begin
        chk($sformatf("stream write c%0d", i), int'(l_write), 'hFF);
        chk($sformatf("stream tag c%0d", i), int'(l_din[3][9]), (i - 1) % 2);
        chk($sformatf("stream coef3 c%0d", i), coef(l_din[3]), ((i - 1) % 2) ? 40 : 58);
      end
      tick();
    end
    l_empty = 2'b11;

    // Port 5 full on flux0: flux1 keeps streaming, flux0 parks one token.
    do_reset();
    l_dout[0] = 4'b0_110; l_dout[1] = 4'b1_000;
    tick();
    l_full[5] = 2'b01;
    l_empty = 2'b00;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("full read c%0d", i), int'(l_read), (i == 0) ? 1 : 2);
      if (i < 2) chk($sformatf("full write c%0d", i), int'(l_write), 0);
      else begin
        chk($sformatf("full write c%0d", i), int'(l_write), 'hFF);
        chk($sformatf("full tag c%0d", i), int'(l_din[0][9]), 1);
        chk($sformatf("full coef3 c%0d", i), coef(l_din[3]), 64);
      end
      tick();
    end
    l_full[5] = 2'b00;
    #1;
    chk("release write", int'(l_write), 'hFF);
    chk("release tag", int'(l_din[4][9]), 0);
    chk("release coef4", coef(l_din[4]), 58);
    chk("release read", int'(l_read), 1);
    tick();
    l_empty = 2'b11;

    // Asynchronous reset mid-stream with held entries.
    do_reset();
    l_dout[0] = 4'b0_010; l_dout[1] = 4'b1_100;
    tick();
    l_empty = 2'b00;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("midrst read", int'(l_read), 0);
    chk("midrst write", int'(l_write), 0);
    chk("midrst din3", int'(l_din[3]), 0);
    l_empty = 2'b11;
    tick();
    rst = 1'b0;
    #1;
    chk("postrst write0", int'(l_write), 0);
    tick();
    #1;
    chk("postrst write1", int'(l_write), 0);
    tick();
    l_empty = 2'b10;
    #1;
    chk("postrst read", int'(l_read), 1);
    chk("postrst write2", int'(l_write), 0);
    tick();
    l_empty = 2'b11;
    #1;
    chk("postrst fresh write", int'(l_write), 'hFF);
    chk("postrst fresh coef3", coef(l_din[3]), 58);

    // Odd luma alpha is consumed and folded to alpha 4.
    do_reset();
    tick();
    l_dout[0] = 4'b0_101;
    l_empty = 2'b10;
    #1;
    chk("odd read", int'(l_read), 1);
`ifdef COEFF_ALPHA_ERR_EN
    chk("odd err before", int'(l_err), 0);
`endif
    tick();
    l_empty = 2'b11;
    #1;
    chk("odd write", int'(l_write), 'hFF);
    for (int k = 0; k < 8; k++) chk($sformatf("odd coef%0d", k), coef(l_din[k]), exp4[k]);
`ifdef COEFF_ALPHA_ERR_EN
    chk("odd err set", int'(l_err), 1);
    tick(); tick();
    #1;
    chk("odd err held", int'(l_err), 1);
    chk("chroma err clear", int'(c_err), 0);
    rst = 1'b1;
    #1;
    chk("odd err rst", int'(l_err), 0);
    tick();
    rst = 1'b0;
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
